universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised WIDTH-bit register with synchronous reset, clock enable and eight operating modes: hold, shift left/right, rotate left/right, arithmetic shift right, parallel load and clear. It generalises the single-bit D flip-flop into the multi-bit storage and serialisation element used by serial-link, LFSR and bit-banging blocks. A saturating shift counter flags when a loaded word has been fully shifted out.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, '0 (WIDTH bits), value loaded into q by reset and by CLEAR.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  clock enable; 0 holds all state.
- mode  in  3  operation select, encodings under Operation.
- d  in  WIDTH  parallel load data.
- sin_lsb  in  1  serial input shifted into bit 0 by SHL.
- sin_msb  in  1  serial input shifted into bit WIDTH-1 by SHR.
- q  out  WIDTH  register contents.
- q_bar  out  WIDTH  ~q, combinational.
- sout_msb  out  1  q[WIDTH-1], combinational.
- sout_lsb  out  1  q[0], combinational.
- shift_cnt  out  $clog2(WIDTH+1)  shifts/rotates since the last LOAD/CLEAR/reset; saturates at WIDTH.
- drained  out  1  registered; high when shift_cnt == WIDTH.

## Operation
- Priority at each edge: reset > !en > mode.
- reset=1: q <= RESET_VALUE, shift_cnt <= 0, drained <= 0, regardless of en or mode.
- en=0: q, shift_cnt and drained hold.
- mode encodings, with en=1:
  - 000 HOLD: q unchanged; shift_cnt unchanged.
  - 001 SHL: q <= {q[W-2:0], sin_lsb}.
  - 010 SHR: q <= {sin_msb, q[W-1:1]}.
  - 011 ROL: q <= {q[W-2:0], q[W-1]}.
  - 100 ROR: q <= {q[0], q[W-1:1]}.
  - 101 ASR: q <= {q[W-1], q[W-1:1]}; sign bit preserved.
  - 110 LOAD: q <= d; shift_cnt <= 0.
  - 111 CLEAR: q <= RESET_VALUE; shift_cnt <= 0.
- shift_cnt increments by 1 for SHL, SHR, ROL, ROR and ASR, and saturates at WIDTH with no wrap.
- drained is asserted on the same edge shift_cnt reaches WIDTH. It clears on LOAD, CLEAR or reset.
- Serial inputs are sampled only in their own mode. They are ignored in all other modes.

## Timing
- Each operation completes in one cycle. q reflects the operation on the edge after mode/en are sampled.
- q_bar, sout_msb and sout_lsb follow q combinationally, with no added latency.
- Reset value of every output:
  - q = RESET_VALUE
  - q_bar = ~RESET_VALUE
  - sout_msb = RESET_VALUE[W-1]
  - sout_lsb = RESET_VALUE[0]
  - shift_cnt = 0
  - drained = 0
- Reset asserted mid-sequence (for example partway through a shift-out) aborts it at the next edge, with no residual count.
- LOAD on the cycle after drained rises: shift_cnt = 0 and drained = 0 on that same edge.
- Continued shifting after saturation: q keeps shifting, while shift_cnt stays at WIDTH and drained stays 1.
- Parallel/serial round-trip: LOAD followed by exactly WIDTH SHL cycles presents every loaded bit on sout_msb, MSB first. The bit is valid in the cycle before each shift edge.

## Structure
- Shared package usr_pkg holds:
  - the mode encodings as localparams: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_LOAD, MODE_CLEAR;
  - a 3-bit usr_mode_t typedef.
- Single module with one sequential process for q, shift_cnt and drained, plus a combinational next-state mux. No sub-module is needed.
- Elaboration-time check: WIDTH < 2 is a fatal error.

## Test plan
- Reset: drive reset=1 with en=1 and mode=LOAD, d=8'hFF. Required response: q=8'h00, shift_cnt=0, drained=0, q_bar=8'hFF.
- Load and shift-out: LOAD 8'hA5, then 8×SHL with sin_lsb=0. Required response:
  - sout_msb sequence 1,0,1,0,0,1,0,1;
  - q=8'h00 at the end;
  - drained rises on the 8th shift edge;
  - a 9th shift keeps shift_cnt=8.
- Rotate and ASR: LOAD 8'h81 then ROL gives 8'h03; ROR twice gives 8'hC0; LOAD 8'h90 then ASR gives 8'hC8.
- SHR serial fill: LOAD 8'h00, then SHR×3 with sin_msb=1. Required response: q=8'hE0, shift_cnt=3.
- Enable gating: LOAD 8'h3C, then en=0 with mode=SHL for 5 cycles. Required response: q=8'h3C, shift_cnt=0 throughout.
- Reset mid-operation: LOAD 8'hF0, SHL×3, then reset=1 for one cycle. Required response: q=RESET_VALUE, shift_cnt=0. After a subsequent CLEAR, drained stays 0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD  = 3'b000;
  localparam usr_mode_t MODE_SHL   = 3'b001;
  localparam usr_mode_t MODE_SHR   = 3'b010;
  localparam usr_mode_t MODE_ROL   = 3'b011;
  localparam usr_mode_t MODE_ROR   = 3'b100;
  localparam usr_mode_t MODE_ASR   = 3'b101;
  localparam usr_mode_t MODE_LOAD  = 3'b110;
  localparam usr_mode_t MODE_CLEAR = 3'b111;

endpackage

// File: rtl/universal_shift_register.sv
// WIDTH-bit register with shift/rotate/ASR/load/clear modes and a saturating
// shift counter that flags when a loaded word has been fully shifted out.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  usr_mode_t                  mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_lsb,
  input  logic                       sin_msb,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_bar,
  output logic                       sout_msb,
  output logic                       sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       drained
);

  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "universal_shift_register: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic             is_shift;

  always_comb begin
    q_next   = q;
    is_shift = 1'b0;
    cnt_next = shift_cnt;
    case (mode)
      MODE_SHL:   begin q_next = {q[WIDTH-2:0], sin_lsb};  is_shift = 1'b1; end
      MODE_SHR:   begin q_next = {sin_msb, q[WIDTH-1:1]};  is_shift = 1'b1; end
      MODE_ROL:   begin q_next = {q[WIDTH-2:0], q[WIDTH-1]}; is_shift = 1'b1; end
      MODE_ROR:   begin q_next = {q[0], q[WIDTH-1:1]};     is_shift = 1'b1; end
      MODE_ASR:   begin q_next = {q[WIDTH-1], q[WIDTH-1:1]}; is_shift = 1'b1; end
      MODE_LOAD:  begin q_next = d;           cnt_next = '0; end
      MODE_CLEAR: begin q_next = RESET_VALUE; cnt_next = '0; end
      default:    q_next = q;
    endcase
    // Count saturates at WIDTH so drained stays high through extra shifts.
    if (is_shift && (shift_cnt != CNT_MAX)) begin
      cnt_next = shift_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= RESET_VALUE;
      shift_cnt <= '0;
      drained   <= 1'b0;
    end else if (en) begin
      q         <= q_next;
      shift_cnt <= cnt_next;
      drained   <= (cnt_next == CNT_MAX);
    end
  end

  assign q_bar    = ~q;
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// arithmetic reference model of the 8-bit register.
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int W  = 8;
  localparam int RV = 0;

  logic         clk = 1'b0;
  logic         reset, en, sin_lsb, sin_msb;
  usr_mode_t    mode;
  logic [W-1:0] d, q, q_bar;
  logic         sout_msb, sout_lsb, drained;
  logic [3:0]   shift_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state: value as a plain integer, count and drained flag.
  int mq = RV;
  int mc = 0;
  bit md = 1'b0;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q), .q_bar(q_bar),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .shift_cnt(shift_cnt),
    .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},         64'(q),         64'(mq));
    chk({tag, ".q_bar"},     64'(q_bar),     64'(255 - mq));
    chk({tag, ".sout_msb"},  64'(sout_msb),  64'(mq / 128));
    chk({tag, ".sout_lsb"},  64'(sout_lsb),  64'(mq % 2));
    chk({tag, ".shift_cnt"}, 64'(shift_cnt), 64'(mc));
    chk({tag, ".drained"},   64'(drained),   64'(md));
  endtask

  task automatic step(input string tag, input bit r, input bit e, input logic [2:0] m,
                      input logic [7:0] dd, input bit sl, input bit sm);
    int v;
    bit shifted;
    reset = r; en = e; mode = m; d = dd; sin_lsb = sl; sin_msb = sm;
    @(posedge clk);
    v = mq;
    shifted = 1'b0;
    if (r) begin
      v = RV; mc = 0;
    end else if (e) begin
      case (m)
        3'd1: begin v = (v * 2 + int'(sl)) % 256;          shifted = 1'b1; end
        3'd2: begin v = v / 2 + int'(sm) * 128;            shifted = 1'b1; end
        3'd3: begin v = (v * 2) % 256 + v / 128;           shifted = 1'b1; end
        3'd4: begin v = v / 2 + (v % 2) * 128;             shifted = 1'b1; end
        3'd5: begin v = v / 2 + ((v >= 128) ? 128 : 0);    shifted = 1'b1; end
        3'd6: begin v = int'(dd); mc = 0; end
        3'd7: begin v = RV;       mc = 0; end
        default: ;
      endcase
      if (shifted && mc < W) mc++;
    end
    mq = v;
    md = (mc == W);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] pattern;
    reset = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hFF; sin_lsb = 1'b0; sin_msb = 1'b0;

    // Reset beats en and LOAD.
    step("reset", 1, 1, MODE_LOAD, 8'hFF, 0, 0);
    chk("reset.q_const", 64'(q), 64'h00);
    chk("reset.qbar_const", 64'(q_bar), 64'hFF);

    // Load 0xA5 and shift out MSB first.
    pattern = 8'hA5;
    step("load_a5", 0, 1, MODE_LOAD, pattern, 0, 0);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("roundtrip_bit%0d", i), 64'(sout_msb), 64'(pattern[7-i]));
      step("shl", 0, 1, MODE_SHL, 8'h00, 0, 0);
      chk($sformatf("drained_edge%0d", i), 64'(drained), 64'(i == W - 1));
    end
    chk("shiftout.q_zero", 64'(q), 64'h00);
    step("shl_sat", 0, 1, MODE_SHL, 8'h00, 1, 0);
    chk("sat.cnt", 64'(shift_cnt), 64'd8);
    chk("sat.drained", 64'(drained), 64'd1);
    // LOAD right after drain clears the count on the same edge.
    step("load_after_drain", 0, 1, MODE_LOAD, 8'h81, 0, 0);
    chk("reload.drained", 64'(drained), 64'd0);

    // Rotates and arithmetic shift.
    step("rol", 0, 1, MODE_ROL, 8'h00, 1, 1);
    chk("rol.const", 64'(q), 64'h03);
    step("ror1", 0, 1, MODE_ROR, 8'h00, 0, 0);
    step("ror2", 0, 1, MODE_ROR, 8'h00, 0, 0);
    chk("ror.const", 64'(q), 64'hC0);
    step("load_90", 0, 1, MODE_LOAD, 8'h90, 0, 0);
    step("asr", 0, 1, MODE_ASR, 8'h00, 0, 0);
    chk("asr.const", 64'(q), 64'hC8);

    // Serial fill from the top.
    step("load_00", 0, 1, MODE_LOAD, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step("shr_fill", 0, 1, MODE_SHR, 8'h00, 0, 1);
    chk("shr.const", 64'(q), 64'hE0);
    chk("shr.cnt", 64'(shift_cnt), 64'd3);

    // Enable gating.
    step("load_3c", 0, 1, MODE_LOAD, 8'h3C, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("en_off", 0, 0, MODE_SHL, 8'h00, 1, 1);
      chk("en_off.const", 64'(q), 64'h3C);
    end

    // Reset mid shift-out, then CLEAR.
    step("load_f0", 0, 1, MODE_LOAD, 8'hF0, 0, 0);
    for (int i = 0; i < 3; i++) step("shl_mid", 0, 1, MODE_SHL, 8'h00, 0, 0);
    step("reset_mid", 1, 1, MODE_SHL, 8'h00, 1, 1);
    chk("reset_mid.cnt", 64'(shift_cnt), 64'd0);
    step("clear", 0, 1, MODE_CLEAR, 8'hFF, 1, 1);
    chk("clear.drained", 64'(drained), 64'd0);

    // Randomized traffic, shift-heavy so saturation is reached often.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] m;
      bit r, e;
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 7) != 0);
      m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
      step("rand", r, e, m, 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
